// File: rtl/chrono_bcd_counter_if.sv
// Control/status bundle between the stopwatch sequencer and the BCD chronometer core.
// The master side drives strobes and presets; the slave side is the counter.
interface chrono_bcd_counter_if #(
    parameter int N_DIGITS = 4
);
    logic                    tick;
    logic                    start;
    logic                    clr;
    logic                    dir;
    logic                    load;
    logic [4*N_DIGITS-1:0]   load_val;
    logic                    lap;
    logic [4*N_DIGITS-1:0]   q;
    logic [4*N_DIGITS-1:0]   lap_q;
    logic                    running;
    logic                    done;
    logic                    wrap;

    modport master (
        output tick, start, clr, dir, load, load_val, lap,
        input  q, lap_q, running, done, wrap
    );

    modport slave (
        input  tick, start, clr, dir, load, load_val, lap,
        output q, lap_q, running, done, wrap
    );
endinterface

// File: rtl/chrono_bcd_counter.sv
// N-digit synchronous BCD chronometer with start/pause, preset load, lap capture
// and terminal-count handling.
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | stopped, count held, load accepted
// S_RUN   | counting one step per tick
// S_PAUSE | stopped mid-run, count held, load accepted
// S_DONE  | down-count reached zero, ticks ignored
module chrono_bcd_counter #(
    parameter int N_DIGITS    = 4,
    parameter int SEXAGESIMAL = 1,
    parameter int AUTO_STOP   = 1
) (
    input  logic                  clk,
    input  logic                  p,
    chrono_bcd_counter_if.slave   bus
);
    localparam int W = 4 * N_DIGITS;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t         state;
    logic [W-1:0]   q_r;
    logic [W-1:0]   lap_r;
    logic           running_r;
    logic           done_r;
    logic           wrap_r;

    logic [W-1:0]   step_val;
    logic           step_carry;
    logic [W-1:0]   load_sat;
    logic           at_zero;
    logic           step_zero;

    function automatic logic [3:0] digit_max(input int i);
        return (SEXAGESIMAL != 0 && (i % 2) == 1) ? 4'd5 : 4'd9;
    endfunction

    // Single carry/borrow chain shared by both directions; carry out of the top
    // digit marks a full-counter rollover.
    always_comb begin
        logic       c;
        logic [3:0] d;
        c        = 1'b1;
        d        = 4'd0;
        step_val = q_r;
        for (int i = 0; i < N_DIGITS; i++) begin
            d = q_r[4*i +: 4];
            if (c) begin
                if (!bus.dir) begin
                    if (d >= digit_max(i)) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        step_val[4*i +: 4] = digit_max(i);
                    end else begin
                        step_val[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        step_carry = c;
    end

    always_comb begin
        load_sat = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            load_sat[4*i +: 4] = (bus.load_val[4*i +: 4] > digit_max(i)) ?
                                 digit_max(i) : bus.load_val[4*i +: 4];
        end
    end

    assign at_zero   = (q_r == '0);
    assign step_zero = (step_val == '0);

    always_ff @(posedge clk) begin
        if (p) begin
            state     <= S_IDLE;
            q_r       <= '0;
            lap_r     <= '0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            wrap_r <= 1'b0;
            if (bus.lap) lap_r <= q_r;

            if (bus.clr) begin
                state     <= S_IDLE;
                q_r       <= '0;
                lap_r     <= '0;
                running_r <= 1'b0;
                done_r    <= 1'b0;
            end else if (bus.load && (state == S_IDLE || state == S_PAUSE)) begin
                q_r <= load_sat;
            end else if (bus.start) begin
                case (state)
                    S_IDLE, S_PAUSE: begin
                        state     <= S_RUN;
                        running_r <= 1'b1;
                    end
                    S_RUN: begin
                        state     <= S_PAUSE;
                        running_r <= 1'b0;
                    end
                    S_DONE: begin
                        state  <= S_IDLE;
                        done_r <= 1'b0;
                    end
                endcase
            end else if (state == S_RUN && bus.tick) begin
                // Terminal zero stops the run instead of borrowing past it.
                if (bus.dir && AUTO_STOP != 0 && (at_zero || step_zero)) begin
                    state     <= S_DONE;
                    running_r <= 1'b0;
                    done_r    <= 1'b1;
                    q_r       <= '0;
                end else begin
                    q_r    <= step_val;
                    wrap_r <= step_carry;
                end
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.lap_q   = lap_r;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.wrap    = wrap_r;
endmodule

// File: tb/tb_chrono_bcd_counter.sv
// Directed bench for chrono_bcd_counter: one auto-stop instance and one wrapping
// instance share the same stimulus; expected values are hand-computed BCD.
module tb_chrono_bcd_counter;
    logic clk;
    logic p;
    int   n_checks;
    int   n_fail;

    chrono_bcd_counter_if #(.N_DIGITS(4)) bus ();
    chrono_bcd_counter_if #(.N_DIGITS(4)) bus_ns ();

    chrono_bcd_counter #(.N_DIGITS(4), .SEXAGESIMAL(1), .AUTO_STOP(1)) u_dut (
        .clk (clk),
        .p   (p),
        .bus (bus.slave)
    );

    chrono_bcd_counter #(.N_DIGITS(4), .SEXAGESIMAL(1), .AUTO_STOP(0)) u_dut_ns (
        .clk (clk),
        .p   (p),
        .bus (bus_ns.slave)
    );

    assign bus_ns.tick     = bus.tick;
    assign bus_ns.start    = bus.start;
    assign bus_ns.clr      = bus.clr;
    assign bus_ns.dir      = bus.dir;
    assign bus_ns.load     = bus.load;
    assign bus_ns.load_val = bus.load_val;
    assign bus_ns.lap      = bus.lap;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick(input int n);
        for (int i = 0; i < n; i++) begin
            bus.tick = 1'b1;
            cyc();
            bus.tick = 1'b0;
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        cyc();
        bus.load     = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        p            = 1'b1;
        bus.tick     = 1'b0;
        bus.start    = 1'b0;
        bus.clr      = 1'b0;
        bus.dir      = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = 16'h0000;
        bus.lap      = 1'b0;
        cyc();
        cyc();
        p = 1'b0;

        check("rst_q", {16'h0, bus.q}, 32'h0);
        check("rst_lap_q", {16'h0, bus.lap_q}, 32'h0);
        check("rst_running", {31'h0, bus.running}, 32'h0);
        check("rst_done", {31'h0, bus.done}, 32'h0);
        check("rst_wrap", {31'h0, bus.wrap}, 32'h0);

        do_tick(3);
        check("idle_ticks_q", {16'h0, bus.q}, 32'h0000);
        check("idle_ticks_running", {31'h0, bus.running}, 32'h0);

        bus.tick = 1'b1;
        do_start();
        bus.tick = 1'b0;
        check("start_tick_no_step", {16'h0, bus.q}, 32'h0000);
        check("start_running", {31'h0, bus.running}, 32'h1);
        do_tick(10);
        check("ten_ticks_q", {16'h0, bus.q}, 32'h0010);

        do_clr();
        do_load(16'h0059);
        do_start();
        do_tick(1);
        check("carry_0059_q", {16'h0, bus.q}, 32'h0100);
        check("carry_0059_wrap", {31'h0, bus.wrap}, 32'h0);

        do_start();
        check("pause_running", {31'h0, bus.running}, 32'h0);
        do_load(16'h5959);
        do_start();
        do_tick(1);
        check("up_wrap_q", {16'h0, bus.q}, 32'h0000);
        check("up_wrap_pulse", {31'h0, bus.wrap}, 32'h1);
        check("up_wrap_running", {31'h0, bus.running}, 32'h1);
        cyc();
        check("up_wrap_one_cycle", {31'h0, bus.wrap}, 32'h0);

        do_clr();
        bus.dir = 1'b1;
        do_load(16'h0002);
        do_start();
        do_tick(1);
        check("down_0001", {16'h0, bus.q}, 32'h0001);
        do_tick(1);
        check("down_zero_q", {16'h0, bus.q}, 32'h0000);
        check("down_zero_done", {31'h0, bus.done}, 32'h1);
        check("down_zero_running", {31'h0, bus.running}, 32'h0);
        check("down_zero_wrap", {31'h0, bus.wrap}, 32'h0);
        check("ns_zero_q", {16'h0, bus_ns.q}, 32'h0000);
        check("ns_zero_running", {31'h0, bus_ns.running}, 32'h1);
        do_tick(1);
        check("done_hold_q", {16'h0, bus.q}, 32'h0000);
        check("done_hold_done", {31'h0, bus.done}, 32'h1);
        check("ns_down_wrap_q", {16'h0, bus_ns.q}, 32'h5959);
        check("ns_down_wrap_pulse", {31'h0, bus_ns.wrap}, 32'h1);
        cyc();
        check("ns_wrap_one_cycle", {31'h0, bus_ns.wrap}, 32'h0);
        do_start();
        check("done_start_idle_done", {31'h0, bus.done}, 32'h0);
        check("done_start_idle_run", {31'h0, bus.running}, 32'h0);

        do_clr();
        bus.dir = 1'b0;
        do_load(16'h0130);
        do_start();
        bus.lap  = 1'b1;
        bus.tick = 1'b1;
        cyc();
        bus.lap  = 1'b0;
        bus.tick = 1'b0;
        check("lap_q_pre_step", {16'h0, bus.lap_q}, 32'h0130);
        check("lap_q_stepped", {16'h0, bus.q}, 32'h0131);
        do_clr();
        check("clr_q", {16'h0, bus.q}, 32'h0000);
        check("clr_lap_q", {16'h0, bus.lap_q}, 32'h0000);
        check("clr_running", {31'h0, bus.running}, 32'h0);

        do_start();
        do_load(16'h1234);
        check("load_in_run_q", {16'h0, bus.q}, 32'h0000);
        check("load_in_run_running", {31'h0, bus.running}, 32'h1);
        do_start();
        do_load(16'h0090);
        check("load_sat_d1", {16'h0, bus.q}, 32'h0050);
        do_load(16'h9999);
        check("load_sat_all", {16'h0, bus.q}, 32'h5959);

        do_clr();
        bus.dir = 1'b1;
        do_start();
        do_tick(1);
        check("zero_tick_done", {31'h0, bus.done}, 32'h1);
        check("zero_tick_q", {16'h0, bus.q}, 32'h0000);
        do_start();

        do_clr();
        bus.dir = 1'b0;
        do_start();
        do_tick(3);
        check("pre_rst_q", {16'h0, bus.q}, 32'h0003);
        p         = 1'b1;
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        bus.lap   = 1'b1;
        cyc();
        p         = 1'b0;
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        bus.lap   = 1'b0;
        check("mid_rst_q", {16'h0, bus.q}, 32'h0000);
        check("mid_rst_lap_q", {16'h0, bus.lap_q}, 32'h0000);
        check("mid_rst_running", {31'h0, bus.running}, 32'h0);
        check("mid_rst_done", {31'h0, bus.done}, 32'h0);
        check("mid_rst_wrap", {31'h0, bus.wrap}, 32'h0);
        check("mid_rst_ns_q", {16'h0, bus_ns.q}, 32'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
